// File: rtl/ram_arbiter.sv
// Two-master arbiter and access sequencer for the single-port program/data RAM.
// Optional macro ARB_RR_EN: round-robin on simultaneous requests (default fixed priority, port 0 first).
module ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic                win;
  logic                any_req;

  assign any_req = m0_req | m1_req;

`ifdef ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // On a tie the port that was not served most recently goes first.
  assign win = (m0_req && m1_req) ? ~last_grant_q : (m1_req && !m0_req);
`else
  assign win = m1_req && !m0_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      port_q     <= port_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    port_d      = port_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    ram_address = '0;
    ram_data    = '0;
    ram_rden    = 1'b0;
    ram_wren    = 1'b0;
    m0_gnt      = 1'b0;
    m1_gnt      = 1'b0;
    m0_ack      = 1'b0;
    m1_ack      = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          port_d  = win;
          we_d    = win ? m1_we : m0_we;
          addr_d  = win ? m1_addr : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          cnt_d   = 2'(RD_LAT - 1);
          state_d = (win ? m1_we : m0_we) ? WR : RD;
`ifdef ARB_RR_EN
          last_grant_d = win;
`endif
        end
      end
      RD: begin
        ram_rden    = 1'b1;
        ram_address = addr_q;
        m0_gnt      = ~port_q;
        m1_gnt      = port_q;
        // The final RD cycle is the one whose closing edge samples the RAM output.
        if (cnt_q == 2'd0) begin
          if (port_q) begin
            m1_rdata_d = ram_q;
          end else begin
            m0_rdata_d = ram_q;
          end
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      WR: begin
        ram_wren    = 1'b1;
        ram_address = addr_q;
        ram_data    = wdata_q;
        m0_gnt      = ~port_q;
        m1_gnt      = port_q;
        state_d     = ACK;
      end
      ACK: begin
        m0_gnt  = ~port_q;
        m1_gnt  = port_q;
        m0_ack  = ~port_q;
        m1_ack  = port_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Arbitrates the single-port 16K program/data RAM between two bus masters: port 0 is the CPU control unit and port 1 is the loader/debug DMA engine. It sequences each access through the RAM's read latency with a small FSM. Each requester gets a request/acknowledge handshake, so requesters no longer drive the RAM's rden, wren or address directly. It sits between the masters and the RAM instance, and is the only driver of the RAM pins.

Parameters:
ADDR_W, 16, address width of requesters and RAM.
DATA_W, 8, data width.
RD_LAT, 2, number of cycles the address and rden are held before ram_q is sampled. Legal range 1..4.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
m0_req  in  1  port 0 (CPU) access request, level
m0_we  in  1  port 0: 1 = write, 0 = read
m0_addr  in  ADDR_W  port 0 address
m0_wdata  in  DATA_W  port 0 write data
m0_gnt  out  1  port 0 access in progress
m0_ack  out  1  port 0 completion pulse
m0_rdata  out  DATA_W  port 0 last read data, registered
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_ack, m1_rdata  same as port 0, for port 1 (DMA)
ram_address  out  ADDR_W  RAM address
ram_data  out  DATA_W  RAM write data
ram_rden  out  1  RAM read enable
ram_wren  out  1  RAM write enable
ram_q  in  DATA_W  RAM read data

Behaviour:
- Reset values:
  - State IDLE.
  - All gnt and ack signals 0.
  - m0_rdata and m1_rdata 0x00.
  - ram_rden and ram_wren 0; ram_address and ram_data 0.
  - Reset mid-access aborts at the next edge: no ack is issued, and a write is not repeated.
- FSM states: IDLE, RD, WR, ACK.
- IDLE:
  - The request is sampled at cycle t.
  - Winner selection: if only one req is high, that port wins. If both are high, port 0 wins (fixed priority; see Optional Feature).
  - The winner's addr, we and wdata are latched into internal registers at the t edge.
  - Next state is RD if we=0, else WR. With no req, stay IDLE.
- RD:
  - Lasts RD_LAT cycles (t+1 .. t+RD_LAT) using a down-counter.
  - ram_rden=1; ram_address = latched address.
  - ram_q is captured into the granted port's rdata at the edge ending the last RD cycle.
  - Next state ACK.
- WR:
  - Lasts exactly one cycle (t+1).
  - ram_wren=1; ram_address and ram_data = latched values.
  - Next state ACK.
- ACK:
  - One cycle. The granted port's ack=1, and its rdata is already valid in this cycle.
  - Next state is always IDLE.
- Latency from the req-sample cycle t:
  - Read: ack at t+RD_LAT+1 (t+3 at the default RD_LAT).
  - Write: ack at t+2.
  - A continuously held req restarts in IDLE, so one mandatory IDLE cycle separates transactions.
- gnt is high from the first RD/WR cycle through the ACK cycle, for the winning port only.
- Exclusivity and holding:
  - ram_rden and ram_wren are never both 1.
  - At most one gnt and one ack are high at a time.
  - The non-granted port's rdata holds its value; writes never modify rdata.
- Protocol rules:
  - A requester holds req, we, addr and wdata stable until ack.
  - Inputs are latched at grant, so changes after grant have no effect.
  - If req is dropped mid-access, the access completes and ack is still pulsed.
  - The losing requester keeps req high and is served at the next IDLE.
- Outputs in IDLE and ACK: ram_rden=0, ram_wren=0, ram_address=0, ram_data=0.

Optional Feature:
Macro ARB_RR_EN.
- Defined: round-robin on ties.
  - A last_grant register (reset value 1) records the most recently granted port.
  - On a tie, the port not equal to last_grant wins, so port 0 wins the first tie after reset.
  - A single requester always wins regardless of last_grant.
- Undefined: fixed priority, port 0 always wins ties. Port 1 can starve, which is acceptable for CPU-first operation.

Test Plan:
- RAM[0x1000]=0xA9; m0 reads 0x1000, req sampled at t -> ram_rden=1 with address 0x1000 at t+1 and t+2; m0_ack=1 and m0_rdata=0xA9 at t+3; m1 signals stay 0.
- m1 writes 0x5A to 0x0042, req sampled at t -> ram_wren=1, address 0x0042, data 0x5A at t+1; m1_ack at t+2. A following m0 read of 0x0042 returns 0x5A.
- m0 and m1 both issue reads at t:
  - Without ARB_RR_EN: m0_ack at t+3, then m1 is sampled at t+4 and m1_ack at t+7.
  - With ARB_RR_EN and both req held: grants alternate 0,1,0,1 over four transactions.
- m0 holds req for three reads of 0x1000/0x1001/0x1002 (holding 0x01/0x02/0x03) -> acks at t+3, t+7, t+11 with the matching rdata; rden and wren never overlap.
- reset asserted during the second RD cycle -> next cycle: all outputs zero, no ack, state IDLE; an m0 read issued afterwards completes normally.
- RD_LAT=4 build, single read -> rden held 4 cycles, ack at t+5.
